// File: rtl/u_interpolator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : u_interpolator_pkg
// Purpose  : Shared definitions for the U(t) interpolator: FSM state
//            encoding, the Q0.16 unity constant and the default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package u_interpolator_pkg;

    localparam int C_ADDRESS_WIDTH  = 13;
    localparam int C_DATA_WIDTH     = 64;
    localparam int C_CUR_DATA_WIDTH = 17;

    // 1.0 in Q0.16; needs 17 bits because ALPHA = 0 must weight U0 fully.
    localparam logic [16:0] C_Q16_ONE = 17'h1_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_CALC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/u_interpolator_lerp_unit.sv
`default_nettype none
// ============================================================================
// Module   : lerp_unit
// Purpose  : Combinational Q0.16 linear interpolation of two 16-bit values:
//            r = floor((a*(1-alpha) + b*alpha)), alpha in Q0.16.
// Ports    : a, b   - 16-bit endpoints
//            alpha  - 16-bit unsigned Q0.16 fraction
//            r      - CUR_DATA_WIDTH result (top bit is the carry, always 0)
// Revision : 1.0 - initial release
// ============================================================================
module lerp_unit
    import u_interpolator_pkg::*;
#(
    parameter int CUR_DATA_WIDTH = C_CUR_DATA_WIDTH
)
(
    input  logic [15:0]               a,
    input  logic [15:0]               b,
    input  logic [15:0]               alpha,
    output logic [CUR_DATA_WIDTH-1:0] r
);

    logic [16:0] w_weight_a;
    logic [32:0] w_prod_a;
    logic [32:0] w_prod_b;
    logic [32:0] w_sum;

    assign w_weight_a = C_Q16_ONE - {1'b0, alpha};
    assign w_prod_a   = 33'(a) * 33'(w_weight_a);
    assign w_prod_b   = 33'(b) * 33'(alpha);
    // Convex combination: sum < 2^32, so the shifted value always fits 16 bits.
    assign w_sum      = w_prod_a + w_prod_b;
    assign r          = CUR_DATA_WIDTH'(w_sum >> 16);

endmodule
`default_nettype wire

// File: rtl/u_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : u_interpolator
// Purpose  : Interpolates U(t) = U0 + alpha*(U1-U0) element-wise from two
//            sample vectors in the solver RAM and writes it to the U region.
// Ports    : clk, rst              - clock, async active-high reset
//            enable                - level start/hold, low aborts/acknowledges
//            m, alpha              - element count, Q0.16 fraction
//            u0_base/u1_base/u_base- source and destination base addresses
//            rd_add1/2, rd_data1/2 - RAM read ports (1-cycle latency)
//            wr_add/wr_data/wr_en  - RAM write port
//            busy, done            - status
// Revision : 1.0 - initial release
// ============================================================================
module u_interpolator
    import u_interpolator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = C_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = C_DATA_WIDTH,
    parameter int CUR_DATA_WIDTH = C_CUR_DATA_WIDTH
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [15:0]              m,
    input  logic [15:0]              alpha,
    input  logic [ADDRESS_WIDTH-1:0] u0_base,
    input  logic [ADDRESS_WIDTH-1:0] u1_base,
    input  logic [ADDRESS_WIDTH-1:0] u_base,
    output logic [ADDRESS_WIDTH-1:0] rd_add1,
    output logic [ADDRESS_WIDTH-1:0] rd_add2,
    input  logic [DATA_WIDTH-1:0]    rd_data1,
    input  logic [DATA_WIDTH-1:0]    rd_data2,
    output logic [ADDRESS_WIDTH-1:0] wr_add,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_en,
    output logic                     busy,
    output logic                     done
);

    state_t                   r_state, w_state_nxt;
    logic [15:0]              r_m, w_m_nxt;
    logic [15:0]              r_alpha, w_alpha_nxt;
    logic [15:0]              r_i, w_i_nxt;
    logic [15:0]              w_i_inc;
    logic [ADDRESS_WIDTH-1:0] r_u0_base, w_u0_base_nxt;
    logic [ADDRESS_WIDTH-1:0] r_u1_base, w_u1_base_nxt;
    logic [ADDRESS_WIDTH-1:0] r_u_base, w_u_base_nxt;
    logic [ADDRESS_WIDTH-1:0] w_rd_add1_nxt, w_rd_add2_nxt, w_wr_add_nxt;
    logic [DATA_WIDTH-1:0]    w_wr_data_nxt;
    logic                     w_wr_en_nxt, w_busy_nxt, w_done_nxt;
    logic [CUR_DATA_WIDTH-1:0] w_lerp_r;

    // Only the low 16 bits of each RAM word carry data.
    logic [DATA_WIDTH-17:0]   w_unused_rd;
    assign w_unused_rd = rd_data1[DATA_WIDTH-1:16] ^ rd_data2[DATA_WIDTH-1:16];

    assign w_i_inc = r_i + 16'd1;

    lerp_unit #(
        .CUR_DATA_WIDTH (CUR_DATA_WIDTH)
    ) u_lerp (
        .a     (rd_data1[15:0]),
        .b     (rd_data2[15:0]),
        .alpha (r_alpha),
        .r     (w_lerp_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every output is registered: the combinational block below computes the
    // value each output takes in the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_alpha_nxt   = r_alpha;
        w_i_nxt       = r_i;
        w_u0_base_nxt = r_u0_base;
        w_u1_base_nxt = r_u1_base;
        w_u_base_nxt  = r_u_base;
        w_rd_add1_nxt = rd_add1;
        w_rd_add2_nxt = rd_add2;
        w_wr_add_nxt  = wr_add;
        w_wr_data_nxt = wr_data;
        w_wr_en_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_m_nxt       = m;
                    w_alpha_nxt   = alpha;
                    w_u0_base_nxt = u0_base;
                    w_u1_base_nxt = u1_base;
                    w_u_base_nxt  = u_base;
                    w_i_nxt       = 16'd0;
                    if (m == 16'd0) begin
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_FETCH;
                        w_busy_nxt    = 1'b1;
                        w_rd_add1_nxt = u0_base;
                        w_rd_add2_nxt = u1_base;
                    end
                end
            end
            ST_FETCH: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CALC;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_CALC: begin
                // RAM data for the addresses presented in FETCH is valid now.
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt   = ST_WRITE;
                    w_busy_nxt    = 1'b1;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_add_nxt  = r_u_base + ADDRESS_WIDTH'(r_i);
                    w_wr_data_nxt = DATA_WIDTH'(w_lerp_r);
                end
            end
            ST_WRITE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_i_nxt = w_i_inc;
                    if (w_i_inc == r_m) begin
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_FETCH;
                        w_busy_nxt    = 1'b1;
                        w_rd_add1_nxt = r_u0_base + ADDRESS_WIDTH'(w_i_inc);
                        w_rd_add2_nxt = r_u1_base + ADDRESS_WIDTH'(w_i_inc);
                    end
                end
            end
            ST_FINISH: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= '0;
            r_alpha   <= '0;
            r_i       <= '0;
            r_u0_base <= '0;
            r_u1_base <= '0;
            r_u_base  <= '0;
            rd_add1   <= '0;
            rd_add2   <= '0;
            wr_add    <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_m       <= w_m_nxt;
            r_alpha   <= w_alpha_nxt;
            r_i       <= w_i_nxt;
            r_u0_base <= w_u0_base_nxt;
            r_u1_base <= w_u1_base_nxt;
            r_u_base  <= w_u_base_nxt;
            rd_add1   <= w_rd_add1_nxt;
            rd_add2   <= w_rd_add2_nxt;
            wr_add    <= w_wr_add_nxt;
            wr_data   <= w_wr_data_nxt;
            wr_en     <= w_wr_en_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/u_interpolator.md
# u_interpolator

Computes the input vector U(t) for the current Euler step by linear interpolation between two stored sample vectors U0 and U1, element by element, and writes the result into the U region of the shared solver RAM. It runs in the solver's Interpolate phase: the Euler controller raises ENABLE, waits for DONE, then reads U for the B·U product.

## Interface
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word width; only bits [15:0] carry data
- CUR_DATA_WIDTH, 17, working width (16-bit value plus carry)
- CLK  in  1  clock, rising-edge active
- RST  in  1  reset, asynchronous, active-high
- ENABLE  in  1  level start/hold; dropping it aborts or acknowledges
- M  in  16  vector length (element count)
- ALPHA  in  16  interpolation fraction, unsigned Q0.16 (0 = U0, 0xFFFF ≈ U1)
- U0_BASE, U1_BASE, U_BASE  in  ADDRESS_WIDTH  base addresses of sample 0, sample 1, destination
- RD_ADD1, RD_ADD2  out  ADDRESS_WIDTH  RAM read addresses (U0, U1)
- RD_DATA1, RD_DATA2  in  DATA_WIDTH  RAM read data
- WR_ADD  out  ADDRESS_WIDTH  RAM write address
- WR_DATA  out  DATA_WIDTH  RAM write data, zero-extended
- WR_EN  out  1  RAM write strobe
- BUSY  out  1  high while processing
- DONE  out  1  completion, held until ENABLE low

## Operation
- Reset: all outputs 0, state IDLE, element counter 0.
- RAM contract: read data valid one cycle after address presented; write commits on rising CLK with WR_EN high.
- States: IDLE, FETCH, CALC, WRITE, FINISH.
- IDLE: on ENABLE=1 latch M, ALPHA, bases; counter i=0; if M=0 go FINISH, else FETCH.
- FETCH: RD_ADD1=U0_BASE+i, RD_ADD2=U1_BASE+i → CALC.
- CALC: capture RD_DATA1[15:0] (a), RD_DATA2[15:0] (b); compute r = (a·(65536−ALPHA) + b·ALPHA) >> 16 in 33-bit unsigned, floor truncation; result always fits 16 bits → WRITE.
- WRITE: WR_ADD=U_BASE+i, WR_DATA={48'b0,r}, WR_EN=1 for exactly this cycle; i=i+1; if i+1==M → FINISH else FETCH.
- FINISH: DONE=1, BUSY=0; stay until ENABLE=0 → IDLE, DONE=0.
- BUSY=1 in FETCH, CALC, WRITE.
- Address arithmetic modulo 2^ADDRESS_WIDTH; base+i wraps silently.
- ENABLE low in FETCH/CALC/WRITE: abort to IDLE next cycle, WR_EN forced 0 in that cycle, DONE never asserted; elements already written stay.
- ENABLE re-asserted in same cycle as FINISH→IDLE exit: not possible (requires low first); new run starts from IDLE next rising edge.
- Inputs M, ALPHA, bases ignored after latch.
- RST mid-operation: immediate return to IDLE, WR_EN drops asynchronously.

## Timing
- Per element: 3 cycles (FETCH, CALC, WRITE).
- ENABLE rise to DONE high: 3·M + 1 cycles (M=0: 1 cycle).
- First WR_EN: cycle 3 after ENABLE sampled high.
- DONE to IDLE: 1 cycle after ENABLE sampled low.
- Outputs registered; no combinational path from RD_DATA to WR_DATA.

## Structure
- Shared package: state encoding (3-bit), Q0.16 ONE constant (65536), default widths.
- One sub-module: lerp_unit — combinational 16×17 weighted sum (two multipliers, one adder, shift); reusable by other interpolation stages.
- Top: FSM, counter, address generators, output registers.

## Test plan
- M=4, ALPHA=0x8000, U0={100,200,0,65535}, U1={300,200,10,65535} → U={200,200,5,65535}, DONE after 13 cycles.
- ALPHA=0, M=3 → U equals U0 bitwise; ALPHA=0xFFFF, U0=0, U1=65535 → 65534 (floor).
- M=0, ENABLE high → DONE next cycle, WR_EN never high, BUSY never high.
- U_BASE=8190, M=4 → writes at 8190, 8191, 0, 1 (wrap).
- ENABLE dropped during element 2 of M=5 → elements 0,1 written, no further WR_EN, DONE stays 0, next run completes normally.
- RST asserted mid-WRITE → WR_EN, BUSY, DONE 0 immediately; state IDLE; subsequent run correct.
